umi_splitter: RTL and testbench

UMI_SPLITTER -- requirements
Module: umi_splitter

---
 rtl/umi_splitter.sv | 126 ++++++++++++
 tb/tb_umi_splitter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/umi_splitter.sv
// rtl/umi_splitter.sv - UMI class splitter routing packets by bit 0 into two independent 2-entry FIFOs

// Two-entry FIFO with 1-bit pointers and a 2-bit occupancy count.
module umi_splitter_fifo2 #(
    parameter int UW = 256
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          i_wr,
    input  logic [UW-1:0] i_data,
    input  logic          i_rd,
    output logic          o_full,
    output logic          o_valid,
    output logic [UW-1:0] o_data
);

    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic [UW-1:0] r_mem [0:1];

    logic w_push;
    logic w_pop;

    // Guards keep count inside 0..2 even if a caller misbehaves.
    assign w_push  = i_wr && (r_count != 2'd2);
    assign w_pop   = i_rd && (r_count != 2'd0);

    assign o_full  = (r_count == 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rptr];

    // Pointer and count state; a simultaneous push and pop moves both pointers and leaves count alone.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// Top level: bit 0 of the input packet selects the response (1) or request (0) queue.
module umi_splitter #(
    parameter int AW = 64,
    parameter int UW = 256
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [UW-1:0] umi_in_packet,
    output logic          umi_in_ready,
    output logic          umi_resp_out_valid,
    output logic [UW-1:0] umi_resp_out_packet,
    input  logic          umi_resp_out_ready,
    output logic          umi_req_out_valid,
    output logic [UW-1:0] umi_req_out_packet,
    input  logic          umi_req_out_ready
);

    // The address width only keeps the parameter list aligned with the rest of the UMI fabric.
    if (AW > 0) begin : g_aw_present
    end

    logic w_cls;
    logic w_accept;
    logic w_resp_full;
    logic w_req_full;
    logic w_resp_wr;
    logic w_req_wr;
    logic w_resp_rd;
    logic w_req_rd;

    assign w_cls = umi_in_packet[0];

    // Only the queue the current packet targets can stall the input.
    assign umi_in_ready = w_cls ? !w_resp_full : !w_req_full;
    assign w_accept     = umi_in_valid && umi_in_ready;
    assign w_resp_wr    = w_accept && w_cls;
    assign w_req_wr     = w_accept && !w_cls;
    assign w_resp_rd    = umi_resp_out_valid && umi_resp_out_ready;
    assign w_req_rd     = umi_req_out_valid && umi_req_out_ready;

    umi_splitter_fifo2 #(.UW(UW)) u_resp_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .i_wr    (w_resp_wr),
        .i_data  (umi_in_packet),
        .i_rd    (w_resp_rd),
        .o_full  (w_resp_full),
        .o_valid (umi_resp_out_valid),
        .o_data  (umi_resp_out_packet)
    );

    umi_splitter_fifo2 #(.UW(UW)) u_req_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .i_wr    (w_req_wr),
        .i_data  (umi_in_packet),
        .i_rd    (w_req_rd),
        .o_full  (w_req_full),
        .o_valid (umi_req_out_valid),
        .o_data  (umi_req_out_packet)
    );

endmodule

// File: tb/tb_umi_splitter.sv
// tb/tb_umi_splitter.sv - scoreboard testbench for umi_splitter
module tb_umi_splitter;

    localparam int UW = 256;

    logic          clk;
    logic          nreset;
    logic          umi_in_valid;
    logic [UW-1:0] umi_in_packet;
    logic          umi_in_ready;
    logic          umi_resp_out_valid;
    logic [UW-1:0] umi_resp_out_packet;
    logic          umi_resp_out_ready;
    logic          umi_req_out_valid;
    logic [UW-1:0] umi_req_out_packet;
    logic          umi_req_out_ready;

    logic [UW-1:0] exp_resp [$];
    logic [UW-1:0] exp_req  [$];

    int n_pass;
    int n_total;

    umi_splitter #(.AW(64), .UW(UW)) dut (
        .clk                 (clk),
        .nreset              (nreset),
        .umi_in_valid        (umi_in_valid),
        .umi_in_packet       (umi_in_packet),
        .umi_in_ready        (umi_in_ready),
        .umi_resp_out_valid  (umi_resp_out_valid),
        .umi_resp_out_packet (umi_resp_out_packet),
        .umi_resp_out_ready  (umi_resp_out_ready),
        .umi_req_out_valid   (umi_req_out_valid),
        .umi_req_out_packet  (umi_req_out_packet),
        .umi_req_out_ready   (umi_req_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [UW-1:0] got, input logic [UW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    function automatic logic [UW-1:0] mk(input logic [31:0] tag, input logic [7:0] lo);
        logic [UW-1:0] r;
        r = '0;
        r[UW-1 -: 32] = tag;
        r[127:96]     = ~tag;
        r[7:0]        = lo;
        return r;
    endfunction

    // Monitor: every output handshake must match the head of that class's scoreboard queue.
    always @(negedge clk) begin
        if (nreset) begin
            if (umi_resp_out_valid && umi_resp_out_ready) begin
                if (exp_resp.size() == 0) check("resp_unexpected", umi_resp_out_packet, '0 - 1);
                else check("resp_pkt", umi_resp_out_packet, exp_resp.pop_front());
            end
            if (umi_req_out_valid && umi_req_out_ready) begin
                if (exp_req.size() == 0) check("req_unexpected", umi_req_out_packet, '0 - 1);
                else check("req_pkt", umi_req_out_packet, exp_req.pop_front());
            end
        end
    end

    // Present one packet until accepted (bounded), record its expectation, then withdraw it.
    task automatic send(input logic [UW-1:0] pkt);
        bit done;
        done = 0;
        umi_in_valid  = 1'b1;
        umi_in_packet = pkt;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (umi_in_ready) begin
                if (pkt[0]) exp_resp.push_back(pkt);
                else        exp_req.push_back(pkt);
                done = 1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        umi_in_valid = 1'b0;
    endtask

    // Send into an empty FIFO and confirm it surfaces on exactly the right output one cycle later.
    task automatic send_chk(input logic [UW-1:0] pkt);
        send(pkt);
        @(negedge clk);
        check("lat_resp_valid", UW'(umi_resp_out_valid), UW'(pkt[0]));
        check("lat_req_valid",  UW'(umi_req_out_valid),  UW'(!pkt[0]));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_resp.size() != 0 || exp_req.size() != 0) && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        check("drain_empty", UW'(exp_resp.size() + exp_req.size()), 0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        nreset = 1'b0;
        umi_in_valid = 1'b0;
        umi_in_packet = '0;
        umi_resp_out_ready = 1'b0;
        umi_req_out_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            umi_in_valid       = 1'($urandom);
            umi_in_packet      = mk($urandom, 8'($urandom));
            umi_resp_out_ready = 1'($urandom);
            umi_req_out_ready  = 1'($urandom);
            @(negedge clk);
            check("rst_resp_valid", UW'(umi_resp_out_valid), 0);
            check("rst_req_valid",  UW'(umi_req_out_valid), 0);
            check("rst_in_ready",   UW'(umi_in_ready), 1);
        end
        @(posedge clk); #1;
        umi_in_valid = 1'b0;
        nreset = 1'b1;
        umi_resp_out_ready = 1'b1;
        umi_req_out_ready  = 1'b1;

        // Routing by class bit.
        send_chk(mk(32'h0000_0001, 8'hA5));
        send_chk(mk(32'h0000_0002, 8'hA4));
        drain();

        // Response FIFO fills, third response is held off.
        umi_resp_out_ready = 1'b0;
        send(mk(32'h0000_0011, 8'h01));
        send(mk(32'h0000_0012, 8'h03));
        umi_in_valid  = 1'b1;
        umi_in_packet = mk(32'h0000_0013, 8'h05);
        repeat (2) begin
            @(negedge clk);
            check("full_in_ready", UW'(umi_in_ready), 0);
        end
        @(posedge clk); #1;
        umi_in_valid = 1'b0;

        // Request still flows while the response FIFO is full.
        umi_in_packet = mk(32'h0000_0021, 8'h02);
        #1;
        check("indep_in_ready", UW'(umi_in_ready), 1);
        send(mk(32'h0000_0021, 8'h02));
        @(negedge clk);
        check("indep_req_valid", UW'(umi_req_out_valid), 1);
        check("indep_resp_valid", UW'(umi_resp_out_valid), 1);

        // Release backpressure; P1, P2, P3 leave in order.
        @(posedge clk); #1;
        umi_resp_out_ready = 1'b1;
        send(mk(32'h0000_0013, 8'h05));
        drain();

        // Simultaneous push/pop: prime one request, then stream 8 back-to-back.
        umi_req_out_ready = 1'b0;
        send(mk(32'h0000_0030, 8'h00));
        umi_req_out_ready = 1'b1;
        umi_in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            umi_in_packet = mk(32'h0000_0031 + 32'(k), 8'(k * 2));
            @(negedge clk);
            check("pp_in_ready", UW'(umi_in_ready), 1);
            check("pp_req_valid", UW'(umi_req_out_valid), 1);
            if (umi_in_ready) exp_req.push_back(umi_in_packet);
            @(posedge clk); #1;
        end
        umi_in_valid = 1'b0;
        @(negedge clk);
        check("pp_count_one", UW'(umi_req_out_valid), 1);
        drain();

        // Mid-run reset with both FIFOs full.
        umi_resp_out_ready = 1'b0;
        umi_req_out_ready  = 1'b0;
        send(mk(32'h0000_0041, 8'h11));
        send(mk(32'h0000_0042, 8'h13));
        send(mk(32'h0000_0043, 8'h10));
        send(mk(32'h0000_0044, 8'h12));
        umi_in_packet = mk(32'h0000_0045, 8'h01);
        #1;
        check("both_full_resp", UW'(umi_in_ready), 0);
        umi_in_packet = mk(32'h0000_0046, 8'h00);
        #1;
        check("both_full_req", UW'(umi_in_ready), 0);
        nreset = 1'b0;
        #1;
        check("mid_rst_resp_valid", UW'(umi_resp_out_valid), 0);
        check("mid_rst_req_valid",  UW'(umi_req_out_valid), 0);
        check("mid_rst_in_ready",   UW'(umi_in_ready), 1);
        exp_resp.delete();
        exp_req.delete();
        umi_resp_out_ready = 1'b1;
        umi_req_out_ready  = 1'b1;
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_resp_valid", UW'(umi_resp_out_valid), 0);
            check("post_rst_req_valid",  UW'(umi_req_out_valid), 0);
        end
        @(posedge clk); #1;
        send_chk(mk(32'h0000_0051, 8'h77));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
